// File: rtl/clk_div_pkg.sv
// clk_div_pkg
// Shared definitions for the clock-divider controller:
//   state_t        controller state (IDLE, ARMED, RUN, STOPPING), 2-bit encoding
//   DEFAULT_WIDTH  default counter / config field width
//   MIN_DIV        smallest terminal count a configuration may latch
`timescale 1ns/1ps
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        RUN      = 2'd2,
        STOPPING = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH = 6;
    localparam int MIN_DIV       = 1;

endpackage

// File: rtl/div_counter.sv
// div_counter
// WIDTH-bit wrapping period counter used by clk_div_ctrl.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   en           advance the counter this cycle
//   clr          synchronous clear to zero (dominates en)
//   term         terminal count; the counter wraps to 0 after reaching it
//   cnt          current count
//   cnt_nxt      value cnt takes at the next edge
//   at_term      combinational terminal detect (en && cnt == term)
//   tick         registered terminal detect, high the cycle after at_term
`timescale 1ns/1ps
module div_counter
    import clk_div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] cnt_nxt,
    output logic             at_term,
    output logic             tick
);

    assign at_term = en && (cnt == term);

    always_comb begin
        cnt_nxt = cnt;
        if (clr) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = at_term ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= at_term && !clr;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl
// Programmable clock-divider controller. Accepts a configuration over a
// valid/ready handshake, arms, then runs a wrapping period counter in
// continuous or one-shot mode, stopping gracefully at the period boundary.
// Ports:
//   clk, reset         clock and asynchronous active-high reset
//   cfg_valid/ready    configuration handshake (ready in IDLE and ARMED)
//   cfg_div            terminal count, period = cfg_div+1 (0 latched as 1)
//   cfg_high           div_out high time in cycles (not clamped)
//   cfg_oneshot        stop after one period
//   start, stop        level-sampled run / graceful-stop requests
//   busy               high in RUN or STOPPING
//   tick               one-cycle pulse per completed period
//   div_out            duty-programmable divided waveform
//   cnt                current counter value
//   done               one-cycle pulse when a run ends
//   casc_in            (only with CLK_DIV_CASCADE_EN) count enable from an
//                      upstream divider tick
// Build option: define CLK_DIV_CASCADE_EN to add casc_in.
`timescale 1ns/1ps
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int RESET_DIV  = 1,
    parameter int RESET_HIGH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    input  logic             cfg_oneshot,
    input  logic             start,
    input  logic             stop,
`ifdef CLK_DIV_CASCADE_EN
    input  logic             casc_in,
`endif
    output logic             busy,
    output logic             tick,
    output logic             div_out,
    output logic [WIDTH-1:0] cnt,
    output logic             done
);

    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] v);
        return (v == '0) ? WIDTH'(MIN_DIV) : v;
    endfunction

    state_t           state, state_nxt;
    logic [WIDTH-1:0] div_reg, high_reg, high_nxt;
    logic             oneshot_reg;
    logic [WIDTH-1:0] cnt_nxt;
    logic             casc, running, busy_nxt, cfg_accept;
    logic             en, clr, terminal, done_nxt;

`ifdef CLK_DIV_CASCADE_EN
    assign casc = casc_in;
`else
    assign casc = 1'b1;
`endif

    assign running    = (state == RUN) || (state == STOPPING);
    assign busy       = running;
    assign cfg_ready  = (state == IDLE) || (state == ARMED);
    assign cfg_accept = cfg_valid && cfg_ready;
    assign en         = running && casc;
    // Holding the counter clear outside a run makes the ARMED->RUN
    // transition start from zero without a separate clear path.
    assign clr        = !running;

    div_counter #(.WIDTH(WIDTH)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .clr     (clr),
        .term    (div_reg),
        .cnt     (cnt),
        .cnt_nxt (cnt_nxt),
        .at_term (terminal),
        .tick    (tick)
    );

    // Config registers: a config offered together with start in ARMED is
    // latched on the same edge and governs the run from its first period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg     <= WIDTH'(RESET_DIV);
            high_reg    <= WIDTH'(RESET_HIGH);
            oneshot_reg <= 1'b0;
        end else if (cfg_accept) begin
            div_reg     <= clamp_div(cfg_div);
            high_reg    <= cfg_high;
            oneshot_reg <= cfg_oneshot;
        end
    end

    assign high_nxt = cfg_accept ? cfg_high : high_reg;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_accept) state_nxt = ARMED;
            end
            ARMED: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (terminal && (oneshot_reg || stop)) begin
                    state_nxt = ARMED;
                    done_nxt  = 1'b1;
                end else if (stop) begin
                    state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                if (terminal) begin
                    state_nxt = ARMED;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy_nxt = (state_nxt == RUN) || (state_nxt == STOPPING);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            done    <= 1'b0;
            div_out <= 1'b0;
        end else begin
            state   <= state_nxt;
            done    <= done_nxt;
            // Registered from next-state values so div_out lines up with
            // the cnt visible in the same cycle.
            div_out <= busy_nxt && (cnt_nxt < high_nxt);
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
`timescale 1ns/1ps
module tb_clk_div_ctrl;

    localparam int W   = 6;
    localparam int BIG = 1 << 30;

    logic         clk = 1'b0;
    logic         reset, cfg_valid, cfg_oneshot, start, stop;
    logic         cfg_ready, busy, tick, div_out, done;
    logic [W-1:0] cfg_div, cfg_high, cnt;
`ifdef CLK_DIV_CASCADE_EN
    logic         casc_in;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clk_div_ctrl #(.WIDTH(W), .RESET_DIV(1), .RESET_HIGH(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_div     (cfg_div),
        .cfg_high    (cfg_high),
        .cfg_oneshot (cfg_oneshot),
        .start       (start),
        .stop        (stop),
`ifdef CLK_DIV_CASCADE_EN
        .casc_in     (casc_in),
`endif
        .busy        (busy),
        .tick        (tick),
        .div_out     (div_out),
        .cnt         (cnt),
        .done        (done)
    );

    // Observed output bundle: {busy, tick, done, div_out, cfg_ready, cnt}
    wire [W+4:0] obs = {busy, tick, done, div_out, cfg_ready, cnt};

    // Reference model: n cycles after the start edge, period p, high time h,
    // run ending (back in ARMED) at cycle e.
    function automatic logic [W+4:0] model(int p, int h, int e, int n);
        logic b, t, dn, dv, r;
        int   c;
        b  = (n < e);
        c  = b ? (n % p) : 0;
        t  = (n > 0) && (n <= e) && ((n % p) == 0);
        dn = (n == e);
        dv = b && (c < h);
        r  = !b;
        return {b, t, dn, dv, r, c[W-1:0]};
    endfunction

    // First period boundary at or after the cycle s in which stop is seen.
    function automatic int end_cycle(int p, int s);
        int t;
        t = s;
        while ((t % p) != p - 1) t++;
        return t + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cfg_valid = 0; cfg_oneshot = 0; start = 0; stop = 0;
        cfg_div = '0; cfg_high = '0;
`ifdef CLK_DIV_CASCADE_EN
        casc_in = 1'b1;
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic send_cfg(int d, int h, bit os);
        cfg_valid = 1'b1; cfg_div = W'(d); cfg_high = W'(h); cfg_oneshot = os;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [W+4:0] ex;
        do_reset();
        reset = 1'b1;
        #1;
        ex = {5'b00001, {W{1'b0}}};
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL reset_values got=%b want=%b", obs, ex);
        end
        step();
        reset = 1'b0;
        start = 1'b1; stop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL idle_ignores_start cyc=%0d got=%b want=%b", i, obs, ex);
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_continuous();
        logic [W+4:0] ex;
        do_reset();
        send_cfg(3, 2, 0);
        do_start();
        for (int n = 0; n < 24; n++) begin
            ex = model(4, 2, BIG, n);
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL continuous n=%0d got=%b want=%b", n, obs, ex);
            end
            step();
        end
    endtask

    task automatic test_oneshot();
        logic [W+4:0] ex;
        int h;
        h = $urandom_range(0, 7);
        do_reset();
        send_cfg(5, h, 1);
        do_start();
        for (int n = 0; n < 18; n++) begin
            ex = model(6, h, 6, n);
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL oneshot n=%0d got=%b want=%b", n, obs, ex);
            end
            step();
        end
    endtask

    task automatic test_stop();
        logic [W+4:0] ex;
        int s_list[4];
        int h, e, s;
        s_list = '{2, 7, 10, 0};
        s_list[3] = $urandom_range(0, 20);
        for (int k = 0; k < 4; k++) begin
            s = s_list[k];
            h = $urandom_range(0, 9);
            e = end_cycle(8, s);
            do_reset();
            send_cfg(7, h, 0);
            do_start();
            for (int n = 0; n <= e + 3; n++) begin
                ex = model(8, h, e, n);
                checks++;
                if (obs !== ex) begin
                    errors++;
                    $display("FAIL stop s=%0d n=%0d got=%b want=%b", s, n, obs, ex);
                end
                stop  = (n >= s) && (n < e);
                start = (n > s) && (n < e);
                step();
            end
            stop = 1'b0; start = 1'b0;
        end
    endtask

    task automatic test_clamp();
        logic [W+4:0] ex;
        do_reset();
        send_cfg(0, 0, 0);
        do_start();
        for (int n = 0; n < 12; n++) begin
            ex = model(2, 0, BIG, n);
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL clamp_div0 n=%0d got=%b want=%b", n, obs, ex);
            end
            step();
        end
        do_reset();
        send_cfg(4, 63, 0);
        do_start();
        for (int n = 0; n < 12; n++) begin
            ex = model(5, 63, BIG, n);
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL high_over_div n=%0d got=%b want=%b", n, obs, ex);
            end
            step();
        end
    endtask

    task automatic test_cfg_during_run();
        logic [W+4:0] ex;
        int e;
        e = end_cycle(4, 13);
        do_reset();
        send_cfg(3, 2, 0);
        do_start();
        for (int n = 0; n <= e; n++) begin
            ex = model(4, 2, e, n);
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL cfg_in_run n=%0d got=%b want=%b", n, obs, ex);
            end
            cfg_valid = (n >= 3) && (n <= 5);
            cfg_div = W'(9); cfg_high = W'(7);
            stop = (n == 13);
            step();
        end
        cfg_valid = 1'b0; stop = 1'b0;
        // config and start together in ARMED
        cfg_valid = 1'b1; cfg_div = W'(2); cfg_high = W'(1); cfg_oneshot = 1'b0;
        start = 1'b1;
        step();
        cfg_valid = 1'b0; start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            ex = model(3, 1, BIG, n);
            checks++;
            if (obs !== ex) begin
                errors++;
                $display("FAIL cfg_with_start n=%0d got=%b want=%b", n, obs, ex);
            end
            step();
        end
    endtask

    task automatic test_reset_midrun();
        logic [W+4:0] ex;
        do_reset();
        send_cfg(5, 4, 0);
        do_start();
        step(); step(); step();
        ex = model(6, 4, BIG, 3);
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL pre_reset_cnt3 got=%b want=%b", obs, ex);
        end
        #1 reset = 1'b1;
        #1;
        ex = {5'b00001, {W{1'b0}}};
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL reset_midrun got=%b want=%b", obs, ex);
        end
        step();
        reset = 1'b0;
        start = 1'b1;
        step(); step();
        start = 1'b0;
        checks++;
        if (obs !== ex) begin
            errors++;
            $display("FAIL after_reset_idle got=%b want=%b", obs, ex);
        end
    endtask

    task automatic test_random();
        logic [W+4:0] ex;
        int d, h, p, s, e;
        bit os;
        do_reset();
        for (int it = 0; it < 12; it++) begin
            d  = $urandom_range(0, 12);
            h  = $urandom_range(0, 15);
            os = 1'($urandom_range(0, 1));
            p  = (d == 0) ? 2 : d + 1;
            s  = $urandom_range(0, 3 * p);
            e  = os ? p : end_cycle(p, s);
            send_cfg(d, h, os);
            do_start();
            for (int n = 0; n <= e + 2; n++) begin
                ex = model(p, h, e, n);
                checks++;
                if (obs !== ex) begin
                    errors++;
                    $display("FAIL random it=%0d d=%0d h=%0d os=%0d s=%0d n=%0d got=%b want=%b",
                             it, d, h, os, s, n, obs, ex);
                end
                stop = !os && (n == s);
                step();
            end
            stop = 1'b0;
        end
    endtask

`ifdef CLK_DIV_CASCADE_EN
    task automatic test_cascade();
        int  mcnt;
        bit  etick;
        bit  en;
        do_reset();
        send_cfg(1, 1, 0);
        casc_in = 1'b0;
        do_start();
        mcnt  = 0;
        etick = 0;
        for (int n = 0; n < 36; n++) begin
            checks++;
            if ((tick !== etick) || (cnt !== W'(mcnt))) begin
                errors++;
                $display("FAIL cascade n=%0d tick=%b cnt=%0d want tick=%b cnt=%0d",
                         n, tick, cnt, etick, mcnt);
            end
            en = ((n % 3) == 2);
            casc_in = en;
            step();
            etick = en && (mcnt == 1);
            if (en) mcnt = (mcnt == 1) ? 0 : mcnt + 1;
        end
        casc_in = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_continuous();
        test_oneshot();
        test_stop();
        test_clamp();
        test_cfg_during_run();
        test_reset_midrun();
        test_random();
`ifdef CLK_DIV_CASCADE_EN
        test_cascade();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
